// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: FSM encodings, bit-timing points, parity sense.
// Optional build macro UART_RX_MAJORITY_EN selects 3-sample majority voting in uart_rx_sampler.
package uart_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int MID_SAMPLE     = 7;

  // XOR of data bits and parity bit for a clean even-parity frame
  localparam logic PARITY_EVEN = 1'b0;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line conditioning for the UART receiver: 2-flop synchronizer and the per-bit decision strobe.
// With UART_RX_MAJORITY_EN the bit value is the majority of ticks 6/7/8, decided at tick 8.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int TICK_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_enable,
  input  logic [TICK_W-1:0] tick,
  input  logic              rxd,
  output logic              rxd_s,
  output logic              bit_val,
  output logic              bit_stb
);

  logic rxd_meta;

  // Flops reset to the idle line level so a reset never looks like a start bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] early_q;

  // Holds the tick-6 and tick-7 samples; the tick-8 sample is the live rxd_s
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      early_q <= 2'b11;
    end else if (sample_enable &&
                 ((tick == TICK_W'(MID_SAMPLE - 1)) || (tick == TICK_W'(MID_SAMPLE)))) begin
      early_q <= {early_q[0], rxd_s};
    end
  end

  assign bit_val = maj3({early_q, rxd_s});
  assign bit_stb = sample_enable && (tick == TICK_W'(MID_SAMPLE + 1));
`else
  assign bit_val = rxd_s;
  assign bit_stb = sample_enable && (tick == TICK_W'(MID_SAMPLE));
`endif

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: start, DATA_BITS data (LSB first), even parity, stop; 16x oversampled.
// Build macro UART_RX_MAJORITY_EN enables majority-of-three bit sampling (see uart_rx_sampler).
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_ENABLE,
  input  logic                 rx_en,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_perror,
  output logic                 rx_ferror
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int CNT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_BITS - 1);

  logic [2:0]           state;
  logic [TICK_W-1:0]    tick;
  logic [CNT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 rxd_s;
  logic                 bit_val;
  logic                 bit_stb;

  uart_rx_sampler #(
    .TICK_W(TICK_W)
  ) u_sampler (
    .clk          (clk),
    .reset        (reset),
    .sample_enable(sample_ENABLE),
    .tick         (tick),
    .rxd          (rxd),
    .rxd_s        (rxd_s),
    .bit_val      (bit_val),
    .bit_stb      (bit_stb)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tick      <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_perror <= 1'b0;
      rx_ferror <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (!rx_en) begin
        state   <= IDLE;
        tick    <= '0;
        bit_cnt <= '0;
      end else if (sample_ENABLE) begin
        tick <= tick + 1'b1;
        case (state)
          IDLE: begin
            tick    <= '0;
            bit_cnt <= '0;
            if (!rxd_s) state <= START;
          end
          START: begin
            if (bit_stb && bit_val) state <= IDLE;
            else if (tick == LAST_TICK) state <= DATA;
          end
          DATA: begin
            if (bit_stb) shreg <= {bit_val, shreg[DATA_BITS-1:1]};
            if (tick == LAST_TICK) begin
              if (bit_cnt == LAST_BIT) state <= PARITY;
              else bit_cnt <= bit_cnt + 1'b1;
            end
          end
          PARITY: begin
            if (bit_stb) par_bit <= bit_val;
            if (tick == LAST_TICK) state <= STOP;
          end
          // Deliver at the stop mid-bit and leave at once so a back-to-back start is caught
          STOP: begin
            if (bit_stb) begin
              rx_data   <= shreg;
              rx_perror <= ((^shreg) ^ par_bit) != PARITY_EVEN;
              rx_ferror <= ~bit_val;
              rx_valid  <= 1'b1;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed frame table, abort sequences, random frames.
module tb_uart_receiver;

  localparam int DB = 8;
  localparam int W  = DB + 2;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          sample_enable;
  logic          rx_en;
  logic          rxd;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          rx_perror;
  logic          rx_ferror;

  int     div = 27;
  int     n_vec = 0;
  int     n_err = 0;
  longint cyc = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  longint       vt_q[$];
  logic [W-1:0] last_word = '0;

  uart_receiver #(
    .DATA_BITS (DB),
    .OVERSAMPLE(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_ENABLE(sample_enable),
    .rx_en        (rx_en),
    .rxd          (rxd),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_perror    (rx_perror),
    .rx_ferror    (rx_ferror)
  );

  // ---------------- clock / tick generation ----------------
  always #10 clk = ~clk;

  initial begin : tick_gen
    int cnt;
    cnt = 0;
    sample_enable = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cnt = (cnt + 1 >= div) ? 0 : cnt + 1;
      sample_enable = (cnt == 0);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rx_valid === 1'b1) begin
      got_q.push_back({rx_ferror, rx_perror, rx_data});
      vt_q.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic do_abort(input int kind);
    if (kind == 1) begin
      reset = 1'b1;
      #1;
      check("reset_abort_outputs", {rx_ferror, rx_perror, rx_data}, '0);
      check("reset_abort_valid", W'(rx_valid), '0);
      rxd = 1'b1;
      wait_clk(4);
      reset = 1'b0;
      last_word = '0;
    end else begin
      rx_en = 1'b0;
      wait_clk(4);
      rxd = 1'b1;
      wait_clk(4);
      rx_en = 1'b1;
    end
  endtask

  // A low stop bit is held only 9 ticks so the receiver never sees a full ghost frame
  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                            input int abort_bit, input int abort_kind);
    logic [10:0] bits;
    int bt;
    bits = {stop, par, data, 1'b0};
    bt = 16 * div;
    for (int i = 0; i < 11; i++) begin
      rxd = bits[i];
      if (i == abort_bit) begin
        wait_clk(bt / 2);
        do_abort(abort_kind);
        return;
      end
      if (i == 10 && !stop) begin
        wait_clk(9 * div);
        rxd = 1'b1;
        wait_clk(7 * div);
      end else begin
        wait_clk(bt);
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic drain(input string name);
    logic [W-1:0] e;
    logic [W-1:0] g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      last_word = e;
      if (got_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL %s: no rx_valid, required word %h", name, e);
      end else begin
        g = got_q.pop_front();
        check(name, g, e);
      end
    end
    n_vec++;
    if (got_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_extra: %0d rx_valid pulses, required 0", name, got_q.size());
      got_q.delete();
    end
    check({name, "_hold"}, {rx_ferror, rx_perror, rx_data}, last_word);
  endtask

  task automatic run_frame(input string name, input logic [7:0] data, input logic par,
                           input logic stop, input logic [W-1:0] exp);
    exp_q.push_back(exp);
    send_frame(data, par, stop, -1, 0);
    drain(name);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t tbl[4];
    logic [7:0] d;
    logic       pe;
    logic       st;
    longint     gap;

    reset = 1'b1;
    rx_en = 1'b1;
    rxd   = 1'b1;
    wait_clk(5);
    check("reset_outputs", {rx_ferror, rx_perror, rx_data}, '0);
    check("reset_valid", W'(rx_valid), '0);
    reset = 1'b0;
    wait_clk(16 * div);

    tbl[0] = '{8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
    tbl[1] = '{8'hA3, 1'b1, 1'b1, 8'hA3, 1'b1, 1'b0};
    tbl[2] = '{8'h0F, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b1};
    tbl[3] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      run_frame($sformatf("table%0d", i), tbl[i].data, tbl[i].par, tbl[i].stop,
                {tbl[i].exp_fe, tbl[i].exp_pe, tbl[i].exp_data});
      wait_clk(16 * div);
    end

    // False start: 4 ticks low, then a good frame
    rxd = 1'b0;
    wait_clk(4 * div);
    rxd = 1'b1;
    wait_clk(2 * 16 * div);
    drain("false_start");
    run_frame("after_false_start", 8'h81, 1'b0, 1'b1, {2'b00, 8'h81});
    wait_clk(16 * div);

    // Back-to-back frames, no idle between stop and next start
    vt_q.delete();
    run_frame("b2b_0", 8'h00, 1'b0, 1'b1, {2'b00, 8'h00});
    run_frame("b2b_1", 8'hFF, 1'b0, 1'b1, {2'b00, 8'hFF});
    n_vec++;
    if (vt_q.size() < 2) begin
      n_err++;
      $display("FAIL b2b_spacing: %0d pulses seen, required 2", vt_q.size());
    end else begin
      gap = vt_q[vt_q.size() - 1] - vt_q[vt_q.size() - 2];
      if (gap < longint'(11 * 16 * div - 2 * div) || gap > longint'(11 * 16 * div + 2 * div)) begin
        n_err++;
        $display("FAIL b2b_spacing: %0d clk, required %0d", gap, 11 * 16 * div);
      end
    end
    wait_clk(16 * div);

    // Reset in the middle of data bit 4, then recovery
    send_frame(8'hE7, 1'b0, 1'b1, 5, 1);
    wait_clk(16 * div);
    drain("reset_abort");
    run_frame("after_reset", 8'h5A, 1'b0, 1'b1, {2'b00, 8'h5A});
    wait_clk(16 * div);

    // rx_en dropped during data bit 2; held outputs must survive
    send_frame(8'hC3, 1'b0, 1'b1, 3, 2);
    wait_clk(16 * div);
    drain("en_abort");

    // Randomized frames against the frame-level model
    for (int i = 0; i < 12; i++) begin
      div = $urandom_range(4, 6);
      wait_clk(16 * div * $urandom_range(1, 2));
      d  = 8'($urandom_range(0, 255));
      pe = ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 4) != 0);
      run_frame($sformatf("rand%0d", i), d, (^d) ^ pe, st, {~st, pe, d});
    end
    wait_clk(16 * div);
    drain("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
